// File: rtl/reg_demux_timeout.sv
// Register-interface demultiplexer: one upstream reg master fanned out to NPORTS slaves by
// base/mask decode, with a registered request, per-transaction timeout and an error counter.
module reg_demux_timeout #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NPORTS  = 4,
    parameter logic [NPORTS-1:0][AW-1:0] BASE_ADDR = '0,
    parameter logic [NPORTS-1:0][AW-1:0] ADDR_MASK = '0,
    parameter int TIMEOUT = 255,
    parameter int ERRW    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    input  logic                 s_write_i,
    input  logic [DW/8-1:0]      s_wstrb_i,
    input  logic [AW-1:0]        s_addr_i,
    input  logic [DW-1:0]        s_wdata_i,
    output logic                 s_ready_o,
    output logic                 s_error_o,
    output logic [DW-1:0]        s_rdata_o,
    output logic [NPORTS-1:0]    m_valid_o,
    output logic                 m_write_o,
    output logic [DW/8-1:0]      m_wstrb_o,
    output logic [AW-1:0]        m_addr_o,
    output logic [DW-1:0]        m_wdata_o,
    input  logic [NPORTS-1:0]    m_ready_i,
    input  logic [NPORTS-1:0]    m_error_i,
    input  logic [NPORTS*DW-1:0] m_rdata_i,
    input  logic                 err_clr_i,
    output logic [ERRW-1:0]      err_cnt_o,
    output logic                 busy_o
);

    localparam int SW   = DW / 8;
    localparam int SELW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int TW   = $clog2(TIMEOUT + 2);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

    state_t            state_reg, state_next;
    logic [SELW-1:0]   sel_reg, sel_next;
    logic              write_reg, write_next;
    logic [SW-1:0]     wstrb_reg, wstrb_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [DW-1:0]     wdata_reg, wdata_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic              resp_err_reg, resp_err_next;
    logic [DW-1:0]     resp_rdata_reg, resp_rdata_next;
    logic [ERRW-1:0]   err_cnt_reg, err_cnt_next;

    logic [NPORTS-1:0] hit;
    logic              hit_any;
    logic [SELW-1:0]   hit_idx;
    logic [DW-1:0]     port_rdata [NPORTS];
    logic              timeout_hit;

    // Decode is done on the live request so the hit port is known when the request is registered.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign hit[gi]        = ((s_addr_i & ADDR_MASK[gi]) == BASE_ADDR[gi]);
            assign port_rdata[gi] = m_rdata_i[gi*DW +: DW];
            assign m_valid_o[gi]  = (state_reg == FWD) && (sel_reg == SELW'(gi));
        end
    endgenerate

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = SELW'(i);
            end
        end
    end

    assign timeout_hit = TO_EN && (timer_reg == TIMER_LAST);

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        write_next      = write_reg;
        wstrb_next      = wstrb_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        timer_next      = timer_reg;
        resp_err_next   = resp_err_reg;
        resp_rdata_next = resp_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (s_valid_i) begin
                    write_next = s_write_i;
                    wstrb_next = s_wstrb_i;
                    addr_next  = s_addr_i;
                    wdata_next = s_wdata_i;
                    timer_next = '0;
                    if (hit_any) begin
                        sel_next   = hit_idx;
                        state_next = FWD;
                    end else begin
                        resp_err_next   = 1'b1;
                        resp_rdata_next = '0;
                        state_next      = RESP;
                    end
                end
            end
            FWD: begin
                timer_next = timer_reg + 1'b1;
                // A slave response in the expiry cycle takes precedence over the timeout.
                if (m_ready_i[sel_reg]) begin
                    resp_err_next   = m_error_i[sel_reg];
                    resp_rdata_next = (write_reg || m_error_i[sel_reg]) ? '0 : port_rdata[sel_reg];
                    state_next      = RESP;
                end else if (timeout_hit) begin
                    resp_err_next   = 1'b1;
                    resp_rdata_next = '0;
                    state_next      = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_clr_i) begin
            err_cnt_next = '0;
        end else if ((state_reg == RESP) && resp_err_reg && (err_cnt_reg != '1)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            write_reg      <= 1'b0;
            wstrb_reg      <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            timer_reg      <= '0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            write_reg      <= write_next;
            wstrb_reg      <= wstrb_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            timer_reg      <= timer_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign s_ready_o = (state_reg == RESP);
    assign s_error_o = s_ready_o & resp_err_reg;
    assign s_rdata_o = s_ready_o ? resp_rdata_reg : '0;
    assign m_write_o = write_reg;
    assign m_wstrb_o = wstrb_reg;
    assign m_addr_o  = addr_reg;
    assign m_wdata_o = wdata_reg;
    assign err_cnt_o = err_cnt_reg;
    assign busy_o    = (state_reg != IDLE);

endmodule

// File: tb/tb_reg_demux_timeout.sv
// Scoreboard bench for reg_demux_timeout: expected responses are queued at request time and
// compared when s_ready_o pulses; latency, m_valid_o pattern and error counter checked per request.
module tb_reg_demux_timeout;

    localparam int AW = 32, DW = 32, NP = 4, SW = 4, TO = 8, ERRW = 8;
    // port0 0x0xxx, port1 0x3xxx, port2 0x2xxx, port3 0x30xx (overlaps port1)
    localparam logic [NP-1:0][AW-1:0] BASES = {32'h0000_3000, 32'h0000_2000, 32'h0000_3000, 32'h0000_0000};
    localparam logic [NP-1:0][AW-1:0] MASKS = {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic             clk = 1'b0;
    logic             rst_i;
    logic             s_valid_i, s_write_i;
    logic [SW-1:0]    s_wstrb_i;
    logic [AW-1:0]    s_addr_i;
    logic [DW-1:0]    s_wdata_i;
    logic             s_ready_o, s_error_o;
    logic [DW-1:0]    s_rdata_o;
    logic [NP-1:0]    m_valid_o;
    logic             m_write_o;
    logic [SW-1:0]    m_wstrb_o;
    logic [AW-1:0]    m_addr_o;
    logic [DW-1:0]    m_wdata_o;
    logic [NP-1:0]    m_ready_i, m_error_i;
    logic [NP*DW-1:0] m_rdata_i;
    logic             err_clr_i;
    logic [ERRW-1:0]  err_cnt_o;
    logic             busy_o;

    always #5 clk = ~clk;

    reg_demux_timeout #(
        .AW(AW), .DW(DW), .NPORTS(NP), .BASE_ADDR(BASES), .ADDR_MASK(MASKS),
        .TIMEOUT(TO), .ERRW(ERRW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_write_i(s_write_i), .s_wstrb_i(s_wstrb_i),
        .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
        .s_ready_o(s_ready_o), .s_error_o(s_error_o), .s_rdata_o(s_rdata_o),
        .m_valid_o(m_valid_o), .m_write_o(m_write_o), .m_wstrb_o(m_wstrb_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_ready_i(m_ready_i), .m_error_i(m_error_i), .m_rdata_i(m_rdata_i),
        .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    resp_t sb_q[$];
    int    n_cmp   = 0;
    int    n_err   = 0;
    int    txn_id  = 0;
    int    exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        resp_t e;
        if (!rst_i && s_ready_o) begin
            check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("s_rdata", 64'(s_rdata_o), 64'(e.rdata));
                check("s_error", 64'(s_error_o), 64'(e.err));
            end
            $display("txn %0d: rdata=%08h error=%0b err_cnt=%0d", txn_id, s_rdata_o, s_error_o, err_cnt_o);
            txn_id++;
        end
    end

    // port < 0: decode miss. rdy_cyc outside 1..TO: slave never answers in time.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int port, input int rdy_cyc, input logic serr,
                           input logic [DW-1:0] srdata, input logic drop);
        int            resp_cyc = 0;
        int            mv_cnt   = 0;
        int            mv_bad   = 0;
        int            e_lat;
        logic          miss, tmo, e_err;
        logic [DW-1:0] e_rd;
        logic [NP-1:0] e_mv;
        logic [SW-1:0] strb;
        miss  = (port < 0);
        tmo   = !miss && (rdy_cyc < 1 || rdy_cyc > TO);
        e_err = miss || tmo || serr;
        e_rd  = (e_err || wr) ? '0 : srdata;
        e_mv  = miss ? '0 : (4'b0001 << port);
        e_lat = miss ? 1 : (tmo ? TO + 1 : rdy_cyc + 1);
        strb  = wr ? 4'b0110 : 4'b1111;
        sb_q.push_back(resp_t'{rdata: e_rd, err: e_err});
        s_valid_i = 1'b1;
        s_write_i = wr;
        s_addr_i  = addr;
        s_wdata_i = wdata;
        s_wstrb_i = strb;
        for (int c = 1; c <= 40 && resp_cyc == 0; c++) begin
            @(posedge clk); #1;
            if (drop) s_valid_i = 1'b0;
            // Unselected ports chatter with ready+error; the DUT must ignore them.
            m_ready_i = ~e_mv;
            m_error_i = ~e_mv;
            m_rdata_i = {NP{32'hDEAD_BEEF}};
            if (!miss && c == rdy_cyc) begin
                m_ready_i[port]            = 1'b1;
                m_error_i[port]            = serr;
                m_rdata_i[port*DW +: DW]   = srdata;
            end
            if (m_valid_o != '0) begin
                mv_cnt++;
                if (m_valid_o !== e_mv) mv_bad++;
            end
            if (c == 1) begin
                check("busy", 64'(busy_o), 64'd1);
                if (!miss) begin
                    check("m_addr", 64'(m_addr_o), 64'(addr));
                    check("m_write", 64'(m_write_o), 64'(wr));
                    check("m_wdata", 64'(m_wdata_o), 64'(wdata));
                    check("m_wstrb", 64'(m_wstrb_o), 64'(strb));
                end
            end
            if (s_ready_o) resp_cyc = c;
        end
        s_valid_i = 1'b0;
        m_ready_i = '0;
        m_error_i = '0;
        check("latency", 64'(resp_cyc), 64'(e_lat));
        check("m_valid_cycles", 64'(mv_cnt), 64'(e_lat - 1));
        check("m_valid_onehot", 64'(mv_bad), 64'd0);
        if (err_clr_i) exp_cnt = 0;
        else if (e_err && exp_cnt != 255) exp_cnt++;
        @(posedge clk); #1;
        check("err_cnt", 64'(err_cnt_o), 64'(exp_cnt));
        check("busy_idle", 64'(busy_o), 64'd0);
    endtask

    initial begin : stim
        int seen;
        rst_i = 1'b1;
        s_valid_i = 1'b0; s_write_i = 1'b0; s_wstrb_i = '0; s_addr_i = '0; s_wdata_i = '0;
        m_ready_i = '0; m_error_i = '0; m_rdata_i = '0; err_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_s_ready", 64'(s_ready_o), 64'd0);
        check("rst_s_error", 64'(s_error_o), 64'd0);
        check("rst_s_rdata", 64'(s_rdata_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        //      wr    addr          wdata         port rdy serr srdata        drop
        run_txn(1'b0, 32'h0000_2004, 32'h0,         2,  3, 1'b0, 32'hCAFE_0001, 1'b0); // read hit
        run_txn(1'b1, 32'h0000_9000, 32'h1234_5678, -1, 0, 1'b0, 32'h0,         1'b0); // decode miss
        run_txn(1'b0, 32'h0000_0010, 32'h0,         0,  0, 1'b0, 32'h0,         1'b0); // timeout
        run_txn(1'b0, 32'h0000_0020, 32'h0,         0, TO, 1'b0, 32'hA5A5_0002, 1'b0); // ready at expiry
        run_txn(1'b0, 32'h0000_3010, 32'h0,         1,  2, 1'b1, 32'h1111_2222, 1'b0); // overlap + slave error
        run_txn(1'b1, 32'h0000_3100, 32'h55AA_55AA, 1,  1, 1'b0, 32'h7777_8888, 1'b0); // write hit
        run_txn(1'b0, 32'h0000_2FFC, 32'h0,         2,  5, 1'b0, 32'h0BAD_F00D, 1'b1); // valid dropped

        // Reset while forwarding: no response, next request served normally.
        s_valid_i = 1'b1; s_write_i = 1'b0; s_addr_i = 32'h0000_0040; s_wdata_i = '0; s_wstrb_i = 4'hF;
        @(posedge clk); #1;
        check("rstfwd_m_valid_c1", 64'(m_valid_o), 64'd1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("rstfwd_m_valid_c3", 64'(m_valid_o), 64'd0);
        check("rstfwd_busy_c3", 64'(busy_o), 64'd0);
        check("rstfwd_err_cnt", 64'(err_cnt_o), 64'd0);
        exp_cnt = 0;
        rst_i = 1'b0;
        s_valid_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (s_ready_o) seen++;
        end
        check("rstfwd_no_resp", 64'(seen), 64'd0);
        run_txn(1'b0, 32'h0000_2100, 32'h0, 2, 2, 1'b0, 32'h1357_9BDF, 1'b0);

        // Saturation of the error counter, then clear dominating a simultaneous increment.
        for (int n = 0; n < 258; n++) begin
            run_txn(1'b0, 32'h0000_8000 + 32'(n), 32'h0, -1, 0, 1'b0, 32'h0, 1'b0);
        end
        check("err_cnt_sat", 64'(err_cnt_o), 64'd255);
        err_clr_i = 1'b1;
        run_txn(1'b0, 32'h0000_A000, 32'h0, -1, 0, 1'b0, 32'h0, 1'b0);
        err_clr_i = 1'b0;
        run_txn(1'b0, 32'h0000_B000, 32'h0, -1, 0, 1'b0, 32'h0, 1'b0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
